// File: rtl/req_encoder_32to5.sv
// Sequential 32-to-5 request encoder: sticky pending register, one grant per cycle on a valid/ready slot.
// Define REQ_ENC_ROUND_ROBIN_EN for round-robin selection; otherwise the lowest pending index wins.
module req_encoder_32to5 (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] req_i,
  input  logic        flush_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [4:0]  id_o,
  output logic [31:0] pending_o,
  output logic        empty_o
);

  logic [31:0] pending_q;
  logic        valid_q;
  logic [4:0]  id_q;

  logic        load;
  logic        grant;
  logic        sel_found;
  logic [4:0]  sel_idx;
  logic [31:0] take_mask;

  // The slot can take a new index when it is empty or being accepted this cycle.
  assign load      = !valid_q || ready_i;
  assign sel_found = |pending_q;
  assign grant     = load && sel_found;
  assign take_mask = grant ? (32'd1 << sel_idx) : 32'd0;

`ifdef REQ_ENC_ROUND_ROBIN_EN
  logic [4:0] last_q;

  // Search starts one past the last grant; 5-bit index arithmetic wraps modulo 32.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sel_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pending_q[last_q + 5'd1 + 5'(i)]) sel_idx = last_q + 5'd1 + 5'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q <= 5'd31;
    end else if (!flush_i && grant) begin
      last_q <= sel_idx;
    end
  end
`else
  // Walking from the top down leaves the lowest set index in sel_idx.
  always_comb begin
    sel_idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = 5'(i);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (!rst_ni) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
    end else if (flush_i) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      // A request on the bit being taken re-sets it: set wins over take.
      pending_q <= (pending_q & ~take_mask) | req_i;
      if (load) begin
        valid_q <= sel_found;
        if (sel_found) id_q <= sel_idx;
      end
    end
  end

  assign valid_o   = valid_q;
  assign id_o      = id_q;
  assign pending_o = pending_q;
  assign empty_o   = !sel_found && !valid_q;

endmodule

// File: tb/tb_req_encoder_32to5.sv
// Self-checking bench for req_encoder_32to5: directed scenarios plus randomized traffic
// compared against a cycle-level reference model of the pending set and output slot.
module tb_req_encoder_32to5;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] req_i = '0;
  logic        flush_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        valid_o;
  logic [4:0]  id_o;
  logic [31:0] pending_o;
  logic        empty_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  bit [31:0] m_pend;
  bit        m_valid;
  int        m_id;
  int        m_last;

  req_encoder_32to5 dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .flush_i   (flush_i),
    .ready_i   (ready_i),
    .valid_o   (valid_o),
    .id_o      (id_o),
    .pending_o (pending_o),
    .empty_o   (empty_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1);
  end

  function automatic int pick(bit [31:0] p, int last);
    int start;
`ifdef REQ_ENC_ROUND_ROBIN_EN
    start = (last + 1) % 32;
`else
    start = 0;
`endif
    for (int i = 0; i < 32; i++) begin
      if (p[(start + i) % 32]) return (start + i) % 32;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_pend  = '0;
    m_valid = 1'b0;
    m_id    = 0;
    m_last  = 31;
  endtask

  task automatic model_step();
    bit [31:0] nxt;
    int        k;
    if (flush_i) begin
      m_pend  = '0;
      m_valid = 1'b0;
    end else begin
      nxt = m_pend;
      if (!m_valid || ready_i) begin
        k = pick(m_pend, m_last);
        if (k >= 0) begin
          m_valid = 1'b1;
          m_id    = k;
          m_last  = k;
          nxt[k]  = 1'b0;
        end else begin
          m_valid = 1'b0;
        end
      end
      m_pend = nxt | req_i;
    end
  endtask

  // One clock edge; the model follows the same inputs, then outputs settle for sampling.
  task automatic cycle();
    @(posedge clk_i);
    if (rst_ni) model_step();
    #1;
  endtask

  task automatic apply_reset();
    req_i   = '0;
    flush_i = 1'b0;
    ready_i = 1'b0;
    rst_ni  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    req_i  = 32'hFFFF_FFFF;
    ready_i = 1'b1;
    rst_ni = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      cycle();
      n_checks++;
      if ({valid_o, id_o, pending_o, empty_o} !== {1'b0, 5'd0, 32'h0, 1'b1}) begin
        n_fail++;
        $display("FAIL reset_hold: valid=%0b id=%0d pending=%h empty=%0b, expected 0 0 00000000 1",
                 valid_o, id_o, pending_o, empty_o);
      end
    end
    rst_ni = 1'b1;
    cycle();
    n_checks++;
    if (pending_o !== 32'hFFFF_FFFF || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release_pending: pending=%h valid=%0b, expected ffffffff 0", pending_o, valid_o);
    end
    cycle();
    n_checks++;
    if (valid_o !== 1'b1 || id_o !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_first_grant: valid=%0b id=%0d, expected 1 0", valid_o, id_o);
    end
  endtask

  task automatic test_sequence();
    int exp_ids[3] = '{0, 4, 31};
    apply_reset();
    ready_i = 1'b1;
    req_i   = 32'h8000_0011;
    cycle();
    req_i = '0;
    n_checks++;
    if (pending_o !== 32'h8000_0011 || valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_latency: pending=%h valid=%0b, expected 80000011 0", pending_o, valid_o);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (valid_o !== 1'b1 || id_o !== 5'(exp_ids[i])) begin
        n_fail++;
        $display("FAIL seq_grant%0d: valid=%0b id=%0d, expected 1 %0d", i, valid_o, id_o, exp_ids[i]);
      end
    end
    cycle();
    n_checks++;
    if (valid_o !== 1'b0 || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL seq_drained: valid=%0b empty=%0b, expected 0 1", valid_o, empty_o);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    req_i = 32'h80;
    cycle();
    req_i = '0;
    cycle();
    for (int k = 0; k < 10; k++) begin
      req_i = (k == 2) ? 32'h8 : 32'h0;
      cycle();
      n_checks++;
      if (valid_o !== 1'b1 || id_o !== 5'd7) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%0b id=%0d, expected 1 7", k, valid_o, id_o);
      end
    end
    n_checks++;
    if (pending_o !== 32'h8) begin
      n_fail++;
      $display("FAIL bp_pending: pending=%h, expected 00000008", pending_o);
    end
    ready_i = 1'b1;
    cycle();
    n_checks++;
    if (valid_o !== 1'b1 || id_o !== 5'd3 || pending_o !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_release: valid=%0b id=%0d pending=%h, expected 1 3 00000000", valid_o, id_o, pending_o);
    end
    cycle();
    n_checks++;
    if (valid_o !== 1'b0 || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drained: valid=%0b empty=%0b, expected 0 1", valid_o, empty_o);
    end
  endtask

  task automatic test_collision();
    apply_reset();
    ready_i = 1'b1;
    req_i   = 32'h20;
    cycle();
    cycle();
    req_i = '0;
    n_checks++;
    if (valid_o !== 1'b1 || id_o !== 5'd5 || pending_o !== 32'h20) begin
      n_fail++;
      $display("FAIL coll_setwins: valid=%0b id=%0d pending=%h, expected 1 5 00000020", valid_o, id_o, pending_o);
    end
    cycle();
    n_checks++;
    if (valid_o !== 1'b1 || id_o !== 5'd5 || pending_o !== 32'h0) begin
      n_fail++;
      $display("FAIL coll_second: valid=%0b id=%0d pending=%h, expected 1 5 00000000", valid_o, id_o, pending_o);
    end
    cycle();
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_done: valid=%0b, expected 0", valid_o);
    end
  endtask

  task automatic test_flush();
    apply_reset();
    req_i = 32'h1000;
    cycle();
    req_i = 32'hF000;
    cycle();
    n_checks++;
    if (pending_o !== 32'hF000 || valid_o !== 1'b1 || id_o !== 5'd12) begin
      n_fail++;
      $display("FAIL flush_setup: pending=%h valid=%0b id=%0d, expected 0000f000 1 12", pending_o, valid_o, id_o);
    end
    flush_i = 1'b1;
    req_i   = 32'h1;
    cycle();
    flush_i = 1'b0;
    req_i   = '0;
    ready_i = 1'b1;
    n_checks++;
    if (valid_o !== 1'b0 || pending_o !== 32'h0 || id_o !== 5'd12) begin
      n_fail++;
      $display("FAIL flush_clear: valid=%0b pending=%h id=%0d, expected 0 00000000 12", valid_o, pending_o, id_o);
    end
    for (int c = 0; c < 4; c++) begin
      cycle();
      n_checks++;
      if (valid_o !== 1'b0 || empty_o !== 1'b1) begin
        n_fail++;
        $display("FAIL flush_nogrant%0d: valid=%0b id=%0d empty=%0b, expected 0 - 1", c, valid_o, id_o, empty_o);
      end
    end
  endtask

  task automatic test_fairness();
    int exp_id;
    apply_reset();
    ready_i = 1'b1;
    req_i   = 32'h204;
    cycle();
    for (int c = 0; c < 8; c++) begin
      cycle();
`ifdef REQ_ENC_ROUND_ROBIN_EN
      exp_id = (c % 2 == 0) ? 2 : 9;
`else
      exp_id = 2;
`endif
      n_checks++;
      if (valid_o !== 1'b1 || id_o !== 5'(exp_id)) begin
        n_fail++;
        $display("FAIL fair%0d: valid=%0b id=%0d, expected 1 %0d", c, valid_o, id_o, exp_id);
      end
    end
    req_i = '0;
  endtask

  task automatic test_random();
    apply_reset();
    for (int n = 0; n < 2000; n++) begin
      if (n % 500 == 250) begin
        rst_ni = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({valid_o, id_o, pending_o, empty_o} !== {1'b0, 5'd0, 32'h0, 1'b1}) begin
          n_fail++;
          $display("FAIL rand_async_reset@%0d: valid=%0b id=%0d pending=%h empty=%0b, expected 0 0 00000000 1",
                   n, valid_o, id_o, pending_o, empty_o);
        end
        #2;
        rst_ni = 1'b1;
      end
      req_i   = $urandom & $urandom & $urandom;
      ready_i = ($urandom_range(0, 3) != 0);
      flush_i = ($urandom_range(0, 49) == 0);
      cycle();
      n_checks++;
      if (valid_o !== m_valid || pending_o !== m_pend || empty_o !== (m_pend == 0 && !m_valid) ||
          (m_valid && id_o !== 5'(m_id))) begin
        n_fail++;
        $display("FAIL rand@%0d: valid=%0b id=%0d pending=%h empty=%0b, expected %0b %0d %h %0b",
                 n, valid_o, id_o, pending_o, empty_o, m_valid, m_id, m_pend, (m_pend == 0 && !m_valid));
      end
    end
    flush_i = 1'b0;
    req_i   = '0;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_backpressure();
    test_collision();
    test_flush();
    test_fairness();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
